// File: rtl/seq_detect_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_pkg
// Shared definitions for the programmable sequence-detector controller:
//   - controller state encoding
//   - default MAX_LEN / LEN_W / CNT_W values
//   - masked_eq(): compares the low 'len' bits of history and pattern
// No ports (package).
// ---------------------------------------------------------------------------
package seq_detect_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_LEN_W   = 4;
   localparam int DEF_CNT_W   = 8;

   // The compare helper works on the largest supported pattern width; callers
   // zero-extend their narrower operands.
   localparam int CMP_W     = 16;
   localparam int CMP_LEN_W = 5;

   function automatic logic masked_eq(input logic [CMP_W-1:0]     hist,
                                      input logic [CMP_W-1:0]     pat,
                                      input logic [CMP_LEN_W-1:0] len);
      logic [CMP_W-1:0] mask;
      mask = '0;
      for (int i = 0; i < CMP_W; i++) begin
         mask[i] = (i < int'(len));
      end
      return (((hist ^ pat) & mask) == '0);
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// ---------------------------------------------------------------------------
// seq_match_core
// History shift register, fill counter and length-masked comparator for an
// overlapping serial pattern match.
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-low reset
//   clr     in   clear history and fill count
//   shift   in   accept bit_in into the history this cycle
//   bit_in  in   serial bit
//   len     in   active pattern length (1..MAX_LEN)
//   pattern in   pattern, bit [len-1] first expected, bit 0 last
//   hit     out  combinational: the bit being shifted in completes a match
// ---------------------------------------------------------------------------
module seq_match_core
   import seq_detect_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = DEF_LEN_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               shift,
   input  logic               bit_in,
   input  logic [LEN_W-1:0]   len,
   input  logic [MAX_LEN-1:0] pattern,
   output logic               hit
);

   localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] hist_q;
   logic [MAX_LEN-1:0] hist_d;
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W-1:0]   fill_d;

   // The match is evaluated on the history as it will be after this shift,
   // so the controller can register the detect pulse on the same edge.
   always_comb begin
      hist_d = {hist_q[MAX_LEN-2:0], bit_in};
      fill_d = (fill_q == FULL) ? FULL : fill_q + 1'b1;
      hit    = shift && (fill_d >= len) &&
               masked_eq(CMP_W'(hist_d), CMP_W'(pattern), CMP_LEN_W'(len));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (clr) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (shift) begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl
// Reconfigurable overlapping sequence detector with config handshake,
// start/abort sequencing and a saturating match counter.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   cfg_valid    in   configuration offered
//   cfg_ready    out  configuration can be accepted (not in RUN)
//   cfg_pattern  in   pattern, bit [cfg_len-1] first expected
//   cfg_len      in   pattern length, valid range 1..MAX_LEN
//   cfg_target   in   stop after this many matches (0 = until abort)
//   start        in   begin a run (ARMED/DONE only)
//   abort        in   end a run (RUN only)
//   data         in   serial data bit
//   data_valid   in   data qualifier
//   detected     out  registered one-cycle match pulse
//   match_count  out  saturating match count of the current/last run
//   busy         out  in RUN
//   done         out  in DONE
//   err          out  one-cycle pulse on rejected config or start
// ---------------------------------------------------------------------------
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic [CNT_W-1:0]   cfg_target,
   input  logic               start,
   input  logic               abort,
   input  logic               data,
   input  logic               data_valid,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t             state_q;
   state_t             state_d;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic [CNT_W-1:0]   tgt_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic               det_q;
   logic               err_q;
   logic               err_d;
   logic               cfg_acc;
   logic               cfg_ok;
   logic               load_cfg;
   logic               cfg_bad;
   logic               start_ok;
   logic               clr;
   logic               shift;
   logic               hit;

   assign shift = (state_q == S_RUN) && data_valid;

   seq_match_core #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .shift   (shift),
      .bit_in  (data),
      .len     (len_q),
      .pattern (pat_q),
      .hit     (hit)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr      = 1'b0;
      cfg_acc  = cfg_valid && (state_q != S_RUN);
      cfg_ok   = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
      load_cfg = cfg_acc && cfg_ok;
      cfg_bad  = cfg_acc && !cfg_ok;
      // A start offered together with a bad config is rejected with it.
      start_ok = start && ((state_q == S_ARMED) || (state_q == S_DONE)) && !cfg_bad;
      // Rejected config and rejected start in one cycle give a single pulse.
      err_d    = cfg_bad || (start && !start_ok);

      case (state_q)
         S_IDLE: begin
            if (load_cfg) state_d = S_ARMED;
         end
         S_ARMED, S_DONE: begin
            if (start_ok) begin
               state_d = S_RUN;
               clr     = 1'b1;
               cnt_d   = '0;
            end else if (load_cfg) begin
               state_d = S_ARMED;
            end
         end
         S_RUN: begin
            if (hit && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
            // Target completion takes precedence over a coincident abort.
            if (hit && (tgt_q != '0) && (cnt_d == tgt_q)) state_d = S_DONE;
            else if (abort)                               state_d = S_ARMED;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         det_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         det_q   <= hit;
         err_q   <= err_d;
      end
   end

   // Config storage is only meaningful once state leaves IDLE, so it needs
   // no reset; returning to IDLE is what discards it.
   always_ff @(posedge clk) begin
      if (load_cfg) begin
         pat_q <= cfg_pattern;
         len_q <= cfg_len;
         tgt_q <= cfg_target;
      end
   end

   assign cfg_ready   = (state_q != S_RUN);
   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign detected    = det_q;
   assign err         = err_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_ctrl
// Directed stimulus for seq_detect_ctrl. Expected detect pulses are queued by
// the stimulus; a monitor pops one entry per observed pulse and compares the
// pulse cycle, match_count, done and busy.
// ---------------------------------------------------------------------------
module tb_seq_detect_ctrl;

   localparam int ML = 8;
   localparam int LW = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [ML-1:0] cfg_pattern = '0;
   logic [LW-1:0] cfg_len = '0;
   logic [CW-1:0] cfg_target = '0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          data = 1'b0;
   logic          data_valid = 1'b0;
   logic          detected;
   logic [CW-1:0] match_count;
   logic          busy;
   logic          done;
   logic          err;

   seq_detect_ctrl #(.MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_target  (cfg_target),
      .start       (start),
      .abort       (abort),
      .data        (data),
      .data_valid  (data_valid),
      .detected    (detected),
      .match_count (match_count),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int cnt;
      int dn;
      int bz;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every detect pulse must correspond to a queued expectation.
   always @(negedge clk) begin
      if (rst && detected) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_detect: got pulse at cycle %0d, expected none", cyc);
         end else begin
            e = q.pop_front();
            chk("det_cycle", cyc, e.cyc);
            chk("det_count", int'(match_count), e.cnt);
            chk("det_done", int'(done), e.dn);
            chk("det_busy", int'(busy), e.bz);
         end
      end
   end

   // All drivers start and end on a falling edge.
   task automatic send_bit(input logic b, input logic v, input bit h,
                           input int cnt, input int dn, input int bz);
      data       = b;
      data_valid = v;
      if (h) q.push_back('{cyc + 1, cnt, dn, bz});
      @(negedge clk);
      data       = 1'b0;
      data_valid = 1'b0;
   endtask

   task automatic nb(input logic b);
      send_bit(b, 1'b1, 1'b0, 0, 0, 0);
   endtask

   task automatic ib(input logic b);
      send_bit(b, 1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic hb(input logic b, input int cnt, input int dn, input int bz);
      send_bit(b, 1'b1, 1'b1, cnt, dn, bz);
   endtask

   task automatic do_cfg(input logic [ML-1:0] p, input logic [LW-1:0] l,
                         input logic [CW-1:0] t, input logic st);
      cfg_valid   = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_target  = t;
      start       = st;
      @(negedge clk);
      cfg_valid   = 1'b0;
      start       = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_cfg_ready", int'(cfg_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_detected", int'(detected), 0);
      chk("rst_count", int'(match_count), 0);
      rst = 1'b1;
      @(negedge clk);

      // Rejections in IDLE
      do_start();
      chk("idle_start_err", int'(err), 1);
      chk("idle_start_busy", int'(busy), 0);
      @(negedge clk);
      chk("err_one_cycle", int'(err), 0);
      do_cfg(8'b10011, 4'd0, 8'd0, 1'b0);
      chk("len0_err", int'(err), 1);
      do_cfg(8'b10011, 4'd9, 8'd0, 1'b0);
      chk("len9_err", int'(err), 1);
      do_start();
      chk("still_idle_err", int'(err), 1);
      chk("still_idle_busy", int'(busy), 0);

      // Free-running overlapping detection
      do_cfg(8'b10011, 4'd5, 8'd0, 1'b0);
      chk("cfg_ok_err", int'(err), 0);
      do_start();
      chk("start_err", int'(err), 0);
      chk("start_busy", int'(busy), 1);
      nb(1); nb(0); nb(0); nb(1); hb(1, 1, 0, 1);
      nb(0); nb(0); nb(1); hb(1, 2, 0, 1);
      chk("run_busy", int'(busy), 1);
      chk("run_count", int'(match_count), 2);
      do_abort();
      chk("abort_busy", int'(busy), 0);
      chk("abort_count", int'(match_count), 2);

      // Target of two
      do_cfg(8'b10011, 4'd5, 8'd2, 1'b0);
      do_start();
      chk("restart_count", int'(match_count), 0);
      nb(1); nb(0); nb(0); nb(1); hb(1, 1, 0, 1);
      nb(0); nb(0); nb(1); hb(1, 2, 1, 0);
      nb(0); nb(0); nb(1); nb(1); nb(1);
      chk("tgt_done", int'(done), 1);
      chk("tgt_busy", int'(busy), 0);
      chk("tgt_count", int'(match_count), 2);

      // Accepted config in DONE returns to ARMED
      do_cfg(8'b10011, 4'd5, 8'd0, 1'b0);
      chk("done_cfg_done", int'(done), 0);
      chk("done_cfg_ready", int'(cfg_ready), 1);
      chk("done_cfg_count", int'(match_count), 2);

      // Qualified stream with garbage on invalid cycles
      do_start();
      nb(1); ib(1); nb(0); nb(0); ib(1); ib(0); nb(1); hb(1, 1, 0, 1);
      chk("dv_busy", int'(busy), 1);

      // Abort clears nothing; start clears history
      do_abort();
      chk("abort2_count", int'(match_count), 1);
      chk("abort2_busy", int'(busy), 0);
      do_start();
      chk("start2_count", int'(match_count), 0);
      nb(1); nb(0); nb(0); nb(1);
      do_abort();
      do_start();
      nb(1);
      nb(1); nb(0); nb(0); nb(1); hb(1, 1, 0, 1);
      do_abort();

      // Same-cycle config and start
      do_cfg(8'h00, 4'd0, 8'd1, 1'b1);
      chk("combo_bad_err", int'(err), 1);
      chk("combo_bad_busy", int'(busy), 0);
      do_cfg(8'hA5, 4'd8, 8'd1, 1'b1);
      chk("combo_ok_err", int'(err), 0);
      chk("combo_ok_busy", int'(busy), 1);
      nb(1); nb(0); nb(1); nb(0); nb(0); nb(1); nb(0); hb(1, 1, 1, 0);
      chk("len8_done", int'(done), 1);

      // Counter saturation with a single-bit pattern
      do_cfg(8'h01, 4'd1, 8'd0, 1'b1);
      chk("sat_start_done", int'(done), 0);
      chk("sat_start_busy", int'(busy), 1);
      for (int i = 1; i <= 260; i++) hb(1, (i > 255) ? 255 : i, 0, 1);
      chk("sat_count", int'(match_count), 255);

      // Asynchronous reset mid-run, while a detect pulse is showing
      #2 rst = 1'b0;
      #1;
      chk("arst_detected", int'(detected), 0);
      chk("arst_count", int'(match_count), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_err", int'(err), 0);
      chk("arst_cfg_ready", int'(cfg_ready), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_start();
      chk("arst_start_err", int'(err), 1);
      chk("arst_start_busy", int'(busy), 0);

      repeat (3) @(negedge clk);
      chk("pending_detects", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable controller for the overlapping Moore sequence detectors in the FSM library. It accepts a bit pattern (1 to MAX_LEN bits) through a configuration handshake and arms on `start`. It then scans a qualified serial stream with overlapping matches, counts detections, and stops after a target number of matches or on `abort`. It sits between the stimulus/control side and the serial data source, replacing one hard-wired detector per pattern with one reconfigurable, sequenced resource.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..16)
- LEN_W, 4, width of cfg_len; must hold MAX_LEN
- CNT_W, 8, width of match target/counter
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted this cycle when cfg_valid & cfg_ready
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected, bit 0 the last
- cfg_len  in  LEN_W  pattern length
- cfg_target  in  CNT_W  stop after this many matches; 0 = run until abort
- start  in  1  one-cycle request to begin a run
- abort  in  1  one-cycle request to end a run
- data  in  1  serial input bit
- data_valid  in  1  data qualifier; bits with data_valid=0 are ignored
- detected  out  1  registered one-cycle match pulse
- match_count  out  CNT_W  matches in the current/last run, saturating
- busy  out  1  high in RUN
- done  out  1  high in DONE
- err  out  1  one-cycle pulse on a rejected config or start

## Operation
- States: IDLE (no valid config), ARMED (config held), RUN, DONE.
- Reset: state=IDLE; history, fill count, match_count, detected, done, busy and err are all 0; cfg_ready=1.
- cfg_ready=1 in IDLE, ARMED and DONE; 0 in RUN.
- Accepted config with 1 ≤ cfg_len ≤ MAX_LEN: latch pattern, len and target; go to ARMED. Any other cfg_len: pulse err; state and stored config unchanged.
- start in ARMED or DONE: clear history, fill count, match_count and done; enter RUN. start in IDLE or RUN: pulse err; otherwise ignored.
- Same-cycle config and start in ARMED/DONE: the config is applied first, and the run uses the new config. If that config is invalid, both are rejected and err pulses once.
- RUN: on each data_valid bit, history = {history[MAX_LEN-2:0], data} and fill = min(fill+1, MAX_LEN).
  - Match when fill ≥ len and history[len-1:0] == pattern[len-1:0].
  - Detection is overlapping: history is never cleared on a match.
- On a match: detected=1 next cycle; match_count increments, saturating at 2^CNT_W-1.
- When a match brings match_count equal to a nonzero target, go to DONE in the same edge as the final increment.
- abort in RUN: go to ARMED; match_count held; detected is still emitted for a match on the same edge. abort outside RUN is ignored.
- abort and a target-completing match on the same edge: DONE wins.
- DONE: done=1 and holds until start or an accepted config. An accepted config moves to ARMED and clears done.
- Async reset mid-run returns to IDLE immediately and discards the config.

## Timing
- Bit sampled at edge N with data_valid=1 completes a match: detected=1 and match_count updated during cycle N→N+1 (1-cycle latency).
- busy rises the cycle after the start edge; the first bit eligible for scanning is the one sampled on the edge after start.
- done rises in the same cycle as the final detected pulse.
- err is registered: it is high for the cycle after the offending edge.
- There is no combinational path from inputs to outputs.

## Structure
- Package seq_detect_pkg holds:
  - state enum (IDLE, ARMED, RUN, DONE) with a 2-bit encoding
  - default MAX_LEN/LEN_W/CNT_W constants
  - a function computing the length-masked compare
- Sub-module seq_match_core contains the history shift register, fill counter and masked comparator. Interface: clk, rst, clr, shift, bit_in, len, pattern → hit.
- The top level holds the FSM, config registers, counter and handshake.

## Test plan
- Config pattern=5'b10011, len=5, target=0; start; stream 1,0,0,1,1,0,0,1,1 (all valid) → detected after the 5th and 9th bits; match_count=2; busy stays 1.
- Same config with target=2 → done=1 and busy=0 in the cycle of the second detected pulse; later bits produce no pulses; match_count stays 2.
- Interleave data_valid=0 cycles carrying garbage bits in the stream 1,0,0,1,1 → exactly one detected pulse, after the last valid 1.
- cfg_len=0 and cfg_len=MAX_LEN+1 → err pulse each time; state unchanged; start from IDLE → err pulse, busy stays 0.
- Abort after bits 1,0,0,1, then start, then bits 1 → no match (history cleared); the stream 1,0,0,1,1 then matches once.
- Drop rst to 0 asynchronously mid-run → all outputs 0 and state IDLE without a clock edge; a subsequent start → err.
